// File: rtl/foct_adc_demod.sv
// foct_adc_demod
//   Receive-side square-wave demodulator for the FOCT modulation loop.
//   A local phase counter mirrors the DAC driver's 6-phase sequence
//   (+amp, +amp, bias, -amp, -amp, bias). The phase goes through an
//   ADC_LAT-deep tag pipeline so each ADC sample is matched with the phase
//   that produced it. Positive and negative phase samples are accumulated over
//   2^ACC_N_LOG2 periods. At the end of the frame the block outputs
//   difference, sum and an overrange flag, with a one-cycle valid strobe.
//
// Ports
//   Refin_Clk   in   reference clock (shared with DAC driver), rising edge
//   Sys_Rst_n   in   asynchronous active-low reset
//   SYS_START   in   synchronous run enable; low = idle / realign
//   ADC_DATA    in   ADC sample, unsigned offset binary
//   Demod_Out   out  signed pos_sum - neg_sum
//   Sum_Out     out  unsigned pos_sum + neg_sum
//   Overrange   out  some accumulated sample of the frame was 0 or full scale
//   Data_Valid  out  one-cycle pulse when the outputs above are updated
module foct_adc_demod #(
  parameter int ADC_W      = 14,
  parameter int ACC_N_LOG2 = 8,
  parameter int ADC_LAT    = 3
) (
  input  logic                                 Refin_Clk,
  input  logic                                 Sys_Rst_n,
  input  logic                                 SYS_START,
  input  logic [ADC_W-1:0]                     ADC_DATA,
  output logic signed [ADC_W+ACC_N_LOG2+1:0]   Demod_Out,
  output logic [ADC_W+ACC_N_LOG2+1:0]          Sum_Out,
  output logic                                 Overrange,
  output logic                                 Data_Valid
);

  localparam int AW = ADC_W + ACC_N_LOG2 + 1;  // accumulator width
  localparam int OW = AW + 1;                  // result width

  // phase issue
  logic                     r_run;   // a phase was issued at the previous edge
  logic [2:0]               r_p;     // phase issued at the previous edge
  logic [2:0]               w_p;     // phase issued at this edge

  // tag pipeline: stage i holds the phase issued i+1 edges ago
  logic [ADC_LAT-1:0]       r_tvld;
  logic [ADC_LAT-1:0][2:0]  r_tag;

  logic [AW-1:0]            r_pos, r_neg;
  logic [ACC_N_LOG2-1:0]    r_per;
  logic                     r_ovr;

  logic signed [OW-1:0]     r_demod;
  logic [OW-1:0]            r_sum;
  logic                     r_ovr_out;
  logic                     r_dv;

  logic [2:0]               w_q;
  logic                     w_qv;
  logic                     w_pos_smp, w_neg_smp, w_per_end, w_frame_end, w_ovr_smp;
  logic [AW-1:0]            w_data;
  logic [OW-1:0]            w_sum;
  logic signed [OW-1:0]     w_diff;

  // The first edge with SYS_START high always issues phase 0.
  assign w_p = !r_run ? 3'd0 : (r_p == 3'd5) ? 3'd0 : 3'(r_p + 3'd1);

  // Tag of the sample at this edge = phase issued ADC_LAT edges earlier.
  assign w_q  = r_tag[ADC_LAT-1];
  assign w_qv = r_tvld[ADC_LAT-1];

  assign w_pos_smp   = w_qv && (w_q == 3'd0 || w_q == 3'd1);
  assign w_neg_smp   = w_qv && (w_q == 3'd3 || w_q == 3'd4);
  assign w_per_end   = w_qv && (w_q == 3'd5);
  assign w_frame_end = w_per_end && (&r_per);
  assign w_ovr_smp   = (w_pos_smp || w_neg_smp) &&
                       (ADC_DATA == '0 || ADC_DATA == '1);

  assign w_data = AW'(ADC_DATA);
  // The q=5 sample is never accumulated, so the current accumulators are
  // already the complete frame when the frame ends.
  assign w_sum  = {1'b0, r_pos} + {1'b0, r_neg};
  assign w_diff = $signed({1'b0, r_pos}) - $signed({1'b0, r_neg});

  always_ff @(posedge Refin_Clk or negedge Sys_Rst_n) begin
    if (!Sys_Rst_n) begin
      r_run     <= 1'b0;
      r_p       <= '0;
      r_tvld    <= '0;
      r_tag     <= '0;
      r_pos     <= '0;
      r_neg     <= '0;
      r_per     <= '0;
      r_ovr     <= 1'b0;
      r_demod   <= '0;
      r_sum     <= '0;
      r_ovr_out <= 1'b0;
      r_dv      <= 1'b0;
    end else if (!SYS_START) begin
      // Idle / realign: drop the partial frame, hold the last results.
      r_run  <= 1'b0;
      r_p    <= '0;
      r_tvld <= '0;
      r_pos  <= '0;
      r_neg  <= '0;
      r_per  <= '0;
      r_ovr  <= 1'b0;
      r_dv   <= 1'b0;
    end else begin
      r_run     <= 1'b1;
      r_p       <= w_p;
      r_tvld[0] <= 1'b1;
      r_tag[0]  <= w_p;
      for (int i = 1; i < ADC_LAT; i++) begin
        r_tvld[i] <= r_tvld[i-1];
        r_tag[i]  <= r_tag[i-1];
      end
      r_dv <= 1'b0;
      if (w_frame_end) begin
        r_demod   <= w_diff;
        r_sum     <= w_sum;
        r_ovr_out <= r_ovr;
        r_dv      <= 1'b1;
        r_pos     <= '0;
        r_neg     <= '0;
        r_per     <= '0;
        r_ovr     <= 1'b0;
      end else begin
        if (w_pos_smp) r_pos <= r_pos + w_data;
        if (w_neg_smp) r_neg <= r_neg + w_data;
        if (w_ovr_smp) r_ovr <= 1'b1;
        if (w_per_end) r_per <= r_per + 1'b1;
      end
    end
  end

  assign Demod_Out  = r_demod;
  assign Sum_Out    = r_sum;
  assign Overrange  = r_ovr_out;
  assign Data_Valid = r_dv;

endmodule

// File: doc/foct_adc_demod.md
# foct_adc_demod

Receive-side square-wave demodulator for the FOCT modulation loop. The DAC driver emits a 6-phase modulation period: +amp, +amp, bias, −amp, −amp, bias. This block takes the photodetector ADC samples on the same reference clock and tags each sample with its modulation phase, compensating for ADC pipeline latency. It accumulates the positive-phase and negative-phase samples over 2^ACC_N_LOG2 periods, then outputs the difference (demodulated error) and the sum (intensity normalisation) with a one-cycle valid strobe.

## Interface
- ADC_W, 14, ADC sample width, unsigned offset binary.
- ACC_N_LOG2, 8, log2 of modulation periods accumulated per result.
- ADC_LAT, 3, clock edges from phase issue to corresponding sample at ADC_DATA; legal 1..7.
- Refin_Clk  in  1  reference clock, the same clock driving the DAC driver; rising edge used.
- Sys_Rst_n  in  1  reset, asynchronous, active-low.
- SYS_START  in  1  synchronous run enable, shared with the DAC driver; low = idle/realign.
- ADC_DATA  in  ADC_W  ADC sample, sampled every rising edge.
- Demod_Out  out  ADC_W+ACC_N_LOG2+2  signed result: pos_sum − neg_sum.
- Sum_Out  out  ADC_W+ACC_N_LOG2+2  unsigned result: pos_sum + neg_sum.
- Overrange  out  1  at least one accumulated sample in the frame was 0 or all-ones.
- Data_Valid  out  1  one-cycle pulse, outputs updated.

## Operation
- Phase counter p: while SYS_START=1, it issues p=0 at the first edge with SYS_START high, then cycles 0,1,2,3,4,5,0,…
- p, with a valid bit, enters an ADC_LAT-deep tag pipeline. The sample at edge k carries tag q = p issued at edge k−ADC_LAT.
- Sample accumulation by tag:
  - q∈{0,1}: add ADC_DATA to pos_acc.
  - q∈{3,4}: add ADC_DATA to neg_acc.
  - q∈{2,5}: ignored.
  - Invalid tag: ignored.
- Overrange flag: set if an accumulated sample equals 0 or 2^ADC_W−1.
- Accumulator width: pos_acc and neg_acc are ADC_W+ACC_N_LOG2+1 bits unsigned, holding 2·2^N samples at full scale with no overflow. Sum and difference are ADC_W+ACC_N_LOG2+2 bits, exact with no saturation.
- Period counter: counts ACC_N_LOG2 bits and increments on each valid q=5 sample.
- Frame end, on the q=5 sample with period counter = all-ones:
  - Demod_Out, Sum_Out and Overrange are loaded.
  - Data_Valid=1 for one cycle.
  - pos_acc, neg_acc, the period counter and the overrange flag are cleared.
  - The next q=0 sample starts the new frame. No sample is lost or double-counted.
- SYS_START=0, evaluated synchronously at each edge:
  - p, the tag pipeline valid bits, both accumulators, the period counter and the flag are cleared.
  - Demod_Out, Sum_Out and Overrange hold their last values. Data_Valid=0.
  - A partial frame is discarded.
- Reset, asynchronous on Sys_Rst_n low: all registers are cleared. Demod_Out=0, Sum_Out=0, Overrange=0, Data_Valid=0.

## Timing
- Define edge 0 as the first rising edge with SYS_START=1. The first valid sample is at edge ADC_LAT.
- The first frame's last sample is at edge 6·2^N−1+ADC_LAT. Outputs and Data_Valid are registered at that edge.
- Subsequent Data_Valid pulses occur exactly every 6·2^N edges.
- Data_Valid is never high for two consecutive cycles.
- Frame end coincident with SYS_START falling: SYS_START=0 wins, so there are no output updates and no pulse.
- Reset release mid-run: the counter restarts only when SYS_START is next sampled high.

## Test plan
All scenarios use ADC_W=14, ACC_N_LOG2=2, ADC_LAT=3.
- Reset: hold Sys_Rst_n=0 with random ADC_DATA and SYS_START=1 → all outputs 0. Release with SYS_START=0 → outputs stay 0, no Data_Valid.
- Constant ADC_DATA=100 from edge 0 → Data_Valid only in the cycle after edge 26, Demod_Out=0, Sum_Out=1600. The next pulse follows edge 50.
- Tag-aligned square wave: 1000 on q∈{0,1}, 200 on q∈{3,4}, 600 on q∈{2,5} → Demod_Out=6400, Sum_Out=9600, Overrange=0.
- Full scale: 16383 on q∈{0,1} and 0 on q∈{3,4} → Demod_Out=131064, Sum_Out=131064, Overrange=1. The next frame with mid-scale data shows Overrange=0.
- Misalignment check: drive the square wave aligned to p rather than q, i.e. with ADC_LAT ignored → the result differs from 6400. Confirms latency compensation.
- Abort: SYS_START low at edge 15, high again 10 edges later (new edge 0) → no Data_Valid in between, outputs hold the previous frame, next Data_Valid after new edge 26 with full-frame values. Repeat with Sys_Rst_n pulsed at edge 15 → outputs 0 immediately.
